// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the pipelined MIPS core.
// Owns the program counter and presents it as the byte address to the
// combinational instruction memory. The returned word is captured into the
// IF/ID pipeline register with its PC+4 and a valid bit. Stall, flush and
// redirect requests from later stages steer both the PC and IF/ID.
// When the PC walks past the end of instruction memory, fetch freezes.
// The frozen state is left only by a redirect or by reset, and a sticky
// fault flag records that it happened.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 512,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic [31:0] ImemAddress,
  input  logic [31:0] ImemInstruction,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic        AddrFault
);

  // The memory holds IMEM_DEPTH words, so it is compared against the PC's word index.
  localparam logic [29:0] LP_DEPTH_WORDS = 30'(IMEM_DEPTH);
  // The PC is always word aligned, including straight out of reset.
  localparam logic [31:0] LP_RESET_PC    = {RESET_PC[31:2], 2'b00};

  // RUN while the PC addresses real memory; FROZEN once it has run past the end.
  typedef enum logic {
    RUN    = 1'b0,
    FROZEN = 1'b1
  } mode_t;

  logic [31:0] r_pc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pcplus4;
  logic        r_ifid_valid;
  logic        r_addr_fault;

  mode_t       w_mode;
  logic        w_in_range;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_fetch_word;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_pc_next;
  logic [31:0] w_ifid_instr_next;
  logic [31:0] w_ifid_pcplus4_next;
  logic        w_ifid_valid_next;
  logic        w_addr_fault_next;
  logic        w_unused_target_bits;

  // Byte-offset bits of the target are discarded; redirects land on a word boundary.
  assign w_unused_target_bits = ^RedirectTarget[1:0];

  // Address decode, fetch-word gating and the sequential PC increment.
  always_comb begin
    w_in_range    = (r_pc[31:2] < LP_DEPTH_WORDS);
    w_mode        = w_in_range ? RUN : FROZEN;
    // Natural 32-bit wrap: 0xFFFF_FFFC + 4 = 0.
    w_pc_plus4    = r_pc + 32'd4;
    // Whatever the memory drives for an out-of-range address is never used.
    w_fetch_word  = w_in_range ? ImemInstruction : NOP_WORD;
    w_redirect_pc = {RedirectTarget[31:2], 2'b00};
  end

  // Next-PC selection: redirect beats stall, and a frozen PC holds until redirected.
  always_comb begin
    w_pc_next = r_pc;
    if (Redirect) begin
      w_pc_next = w_redirect_pc;
    end else if (Stall) begin
      w_pc_next = r_pc;
    end else if (w_mode == FROZEN) begin
      w_pc_next = r_pc;
    end else begin
      w_pc_next = w_pc_plus4;
    end
  end

  // Next IF/ID contents: a squash wins over a stall, and a stall wins over normal capture.
  always_comb begin
    w_ifid_instr_next   = r_ifid_instr;
    w_ifid_pcplus4_next = r_ifid_pcplus4;
    w_ifid_valid_next   = r_ifid_valid;
    if (Redirect || Flush) begin
      w_ifid_instr_next   = NOP_WORD;
      w_ifid_pcplus4_next = 32'h0000_0000;
      w_ifid_valid_next   = 1'b0;
    end else if (Stall) begin
      w_ifid_instr_next   = r_ifid_instr;
      w_ifid_pcplus4_next = r_ifid_pcplus4;
      w_ifid_valid_next   = r_ifid_valid;
    end else if (w_mode == FROZEN) begin
      w_ifid_instr_next   = NOP_WORD;
      w_ifid_pcplus4_next = 32'h0000_0000;
      w_ifid_valid_next   = 1'b0;
    end else begin
      w_ifid_instr_next   = w_fetch_word;
      w_ifid_pcplus4_next = w_pc_plus4;
      w_ifid_valid_next   = 1'b1;
    end
  end

  // Sticky fault: set on an out-of-range fetch attempt, unless a redirect is leaving it.
  always_comb begin
    w_addr_fault_next = r_addr_fault;
    if ((w_mode == FROZEN) && !Redirect) begin
      w_addr_fault_next = 1'b1;
    end
  end

  // Program counter register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_pc <= LP_RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_ifid_instr   <= NOP_WORD;
      r_ifid_pcplus4 <= 32'h0000_0000;
      r_ifid_valid   <= 1'b0;
    end else begin
      r_ifid_instr   <= w_ifid_instr_next;
      r_ifid_pcplus4 <= w_ifid_pcplus4_next;
      r_ifid_valid   <= w_ifid_valid_next;
    end
  end

  // Address-fault flag; only reset clears it.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_addr_fault <= 1'b0;
    end else begin
      r_addr_fault <= w_addr_fault_next;
    end
  end

  assign ImemAddress       = r_pc;
  assign PC                = r_pc;
  assign IF_ID_Instruction = r_ifid_instr;
  assign IF_ID_PCPlus4     = r_ifid_pcplus4;
  assign IF_ID_Valid       = r_ifid_valid;
  assign AddrFault         = r_addr_fault;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit.
// Memory model: word i holds i*4. Addresses beyond the 512-word memory
// return a recognisable garbage pattern, which the design must never capture.
module tb_instruction_fetch_unit;

  logic        Clk;
  logic        Rst_n;
  logic        Stall;
  logic        Flush;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic [31:0] ImemAddress;
  logic [31:0] ImemInstruction;
  logic [31:0] PC;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic        AddrFault;

  int passed;
  int total;

  instruction_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_DEPTH (512),
    .NOP_WORD   (32'h0000_0000)
  ) dut (
    .Clk               (Clk),
    .Rst_n             (Rst_n),
    .Stall             (Stall),
    .Flush             (Flush),
    .Redirect          (Redirect),
    .RedirectTarget    (RedirectTarget),
    .ImemAddress       (ImemAddress),
    .ImemInstruction   (ImemInstruction),
    .PC                (PC),
    .IF_ID_Instruction (IF_ID_Instruction),
    .IF_ID_PCPlus4     (IF_ID_PCPlus4),
    .IF_ID_Valid       (IF_ID_Valid),
    .AddrFault         (AddrFault)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Combinational instruction memory: mem[i] = i*4 for i < 512.
  always_comb begin
    if (ImemAddress[31:2] < 30'd512) ImemInstruction = {ImemAddress[31:2], 2'b00};
    else                             ImemInstruction = 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] e_instr,
                          input logic [31:0] e_pc4, input logic e_vld);
    chk({tag, ".instr"}, IF_ID_Instruction, e_instr);
    chk({tag, ".pc4"},   IF_ID_PCPlus4,     e_pc4);
    chk({tag, ".valid"}, {31'd0, IF_ID_Valid}, {31'd0, e_vld});
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".pc"},    PC,          32'h0);
    chk({tag, ".iaddr"}, ImemAddress, 32'h0);
    chk_ifid(tag, 32'h0, 32'h0, 1'b0);
    chk({tag, ".fault"}, {31'd0, AddrFault}, 32'd0);
  endtask

  // Wait for one rising edge, then step 1 time unit past it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    Rst_n = 1'b0; Stall = 1'b0; Flush = 1'b0; Redirect = 1'b0; RedirectTarget = 32'h0;
    #2;
    chk_reset_state("reset");
    #1 Rst_n = 1'b1;

    // T1: sequential fetch from address 0.
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_ifid($sformatf("t1_e%0d", k), 32'((k - 1) * 4), 32'(k * 4), 1'b1);
      chk($sformatf("t1_e%0d.pc", k), PC, 32'(k * 4));
    end

    // T2: a three-edge stall at PC 0x10.
    Stall = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("t2_stall%0d.pc", k), PC, 32'h10);
      chk_ifid($sformatf("t2_stall%0d", k), 32'h0C, 32'h10, 1'b1);
    end
    Stall = 1'b0;
    step();
    chk_ifid("t2_release", 32'h10, 32'h14, 1'b1);
    chk("t2_release.pc", PC, 32'h14);

    // Advance to PC 0x20.
    for (int k = 0; k < 3; k++) step();
    chk("t3_pre.pc", PC, 32'h20);

    // T3: redirect to an unaligned target.
    Redirect = 1'b1; RedirectTarget = 32'h43;
    step();
    chk("t3_redir.pc", PC, 32'h40);
    chk_ifid("t3_redir", 32'h0, 32'h0, 1'b0);
    Redirect = 1'b0;
    step();
    chk_ifid("t3_after", 32'h40, 32'h44, 1'b1);
    chk("t3_after.pc", PC, 32'h44);

    // T4: redirect and stall on the same edge; the redirect wins.
    Redirect = 1'b1; Stall = 1'b1; RedirectTarget = 32'h80;
    step();
    chk("t4.pc", PC, 32'h80);
    chk_ifid("t4", 32'h0, 32'h0, 1'b0);
    Redirect = 1'b0; Stall = 1'b0;
    step();
    chk_ifid("t4_after", 32'h80, 32'h84, 1'b1);

    // Stall and flush together: the PC holds and IF/ID becomes a bubble.
    Stall = 1'b1; Flush = 1'b1;
    step();
    chk("sf.pc", PC, 32'h84);
    chk_ifid("sf", 32'h0, 32'h0, 1'b0);
    Stall = 1'b0; Flush = 1'b0;
    step();
    chk_ifid("sf_after", 32'h84, 32'h88, 1'b1);
    chk("sf_after.pc", PC, 32'h88);

    // T5: redirect out of range to word 512.
    Redirect = 1'b1; RedirectTarget = 32'h800;
    step();
    chk("t5_redir.pc", PC, 32'h800);
    chk("t5_redir.fault", {31'd0, AddrFault}, 32'd0);
    Redirect = 1'b0;
    step();
    chk("t5_frz1.pc", PC, 32'h800);
    chk_ifid("t5_frz1", 32'h0, 32'h0, 1'b0);
    chk("t5_frz1.fault", {31'd0, AddrFault}, 32'd1);
    step();
    chk("t5_frz2.pc", PC, 32'h800);
    chk("t5_frz2.valid", {31'd0, IF_ID_Valid}, 32'd0);

    // Last valid word (511) is fetched, after which fetch freezes again.
    Redirect = 1'b1; RedirectTarget = 32'h7FC;
    step();
    chk("t5_last.pc", PC, 32'h7FC);
    Redirect = 1'b0;
    step();
    chk_ifid("t5_last_fetch", 32'h7FC, 32'h800, 1'b1);
    chk("t5_last_fetch.pc", PC, 32'h800);
    step();
    chk("t5_refrz.pc", PC, 32'h800);
    chk("t5_refrz.valid", {31'd0, IF_ID_Valid}, 32'd0);

    // Redirect back to 0; fetch resumes and the fault flag stays set.
    Redirect = 1'b1; RedirectTarget = 32'h0;
    step();
    chk("t5_resume.pc", PC, 32'h0);
    Redirect = 1'b0;
    step();
    chk_ifid("t5_resume", 32'h0, 32'h4, 1'b1);
    chk("t5_resume.pc2", PC, 32'h4);
    chk("t5_resume.fault", {31'd0, AddrFault}, 32'd1);

    // T6: advance to PC 0x30, stall, then assert async reset mid-cycle.
    for (int k = 0; k < 11; k++) step();
    chk("t6_pre.pc", PC, 32'h30);
    Stall = 1'b1;
    step();
    chk("t6_stall.pc", PC, 32'h30);
    #2 Rst_n = 1'b0;
    #1;
    chk_reset_state("t6_async");
    #2 Rst_n = 1'b1; Stall = 1'b0;
    step();
    chk_ifid("t6_after", 32'h0, 32'h4, 1'b1);
    chk("t6_after.pc", PC, 32'h4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Watchdog: the directed sequence finishes long before this bound.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish within 20000 time units");
    $fatal(1);
  end

endmodule
